// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: opcode and sizing constants shared by the instruction
// memory responder and its response pipeline.
//   NOP_INST     - canonical RISC-V NOP (addi x0,x0,0), returned on errors
//                  and presented on imem_rdata while in reset.
//   IMEM_LAT_MAX - largest supported request-to-response latency.
package imem_responder_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam int unsigned IMEM_LAT_MAX = 4;

endpackage

// File: rtl/imem_responder_pipe.sv
// imem_resp_pipe: delay line for {valid, err, data} responses.
//   clk, resetb    - clock and asynchronous active-low reset
//   in_valid/err/data   - response leaving the first register stage
//   out_valid/err/data  - response after STAGES further cycles
// Valid bits clear asynchronously; err/data only load alongside a valid so
// the output data holds its last value while idle. out_err is masked by
// out_valid. With STAGES=0 the block is pure wiring.
module imem_resp_pipe
    import imem_responder_pkg::*;
#(
    parameter int unsigned STAGES = 0
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        in_valid,
    input  logic        in_err,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic        out_err,
    output logic [31:0] out_data
);

    generate
        if (STAGES == 0) begin : g_wire
            assign out_valid = in_valid;
            assign out_err   = in_valid & in_err;
            assign out_data  = in_data;
        end else begin : g_regs
            logic        v_q [STAGES];
            logic        e_q [STAGES];
            logic [31:0] d_q [STAGES];

            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        v_q[i] <= 1'b0;
                        e_q[i] <= 1'b0;
                        d_q[i] <= NOP_INST;
                    end
                end else begin
                    v_q[0] <= in_valid;
                    if (in_valid) begin
                        e_q[0] <= in_err;
                        d_q[0] <= in_data;
                    end
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        v_q[i] <= v_q[i-1];
                        if (v_q[i-1]) begin
                            e_q[i] <= e_q[i-1];
                            d_q[i] <= d_q[i-1];
                        end
                    end
                end
            end

            assign out_valid = v_q[STAGES-1];
            assign out_err   = v_q[STAGES-1] & e_q[STAGES-1];
            assign out_data  = d_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction RAM answering one fetch per
// cycle with a fixed, in-order latency of LATENCY cycles.
//   clk, resetb      - clock and asynchronous active-low reset
//   imem_ready       - fetch request strobe (no backpressure)
//   imem_addr        - fetch byte address
//   imem_rdata       - returned instruction word (NOP on error)
//   imem_valid       - response strobe, one cycle per request
//   imem_err         - response is for a misaligned / out-of-range address
//   prog_we/addr/wdata - program-load write port (word index)
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          imem_ready,
    input  logic [31:0]   imem_addr,
    output logic [31:0]   imem_rdata,
    output logic          imem_valid,
    output logic          imem_err,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata
);

    generate
        if (LATENCY < 1 || LATENCY > IMEM_LAT_MAX) begin : g_bad_latency
            $error("imem_responder: LATENCY must be in 1..%0d", IMEM_LAT_MAX);
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("imem_responder: DEPTH must be a power of two >= 2");
        end
    endgenerate

    // Word offset from BASE_ADDR; the subtraction wraps at 32 bits.
    function automatic logic [29:0] word_offset(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[31:2];
    endfunction

    logic [31:0] ram [DEPTH];

    logic [29:0]   off_word;
    logic          misaligned;
    logic          out_of_range;
    logic          bad;
    logic [AW-1:0] idx;

    always_comb begin
        off_word     = word_offset(imem_addr);
        misaligned   = (imem_addr[1:0] != 2'b00);
        out_of_range = (imem_addr < BASE_ADDR) || ({2'b00, off_word} >= 32'(DEPTH));
        bad          = misaligned | out_of_range;
        idx          = off_word[AW-1:0];
    end

    // Program load; the RAM itself is not part of the reset domain.
    always_ff @(posedge clk) begin
        if (prog_we && resetb) begin
            ram[prog_addr] <= prog_wdata;
        end
    end

    // First stage: synchronous RAM read in the acceptance cycle. Reading the
    // array here alongside the write above gives read-before-write.
    logic        s1_valid;
    logic        s1_err;
    logic [31:0] s1_data;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= NOP_INST;
        end else begin
            s1_valid <= imem_ready;
            if (imem_ready) begin
                s1_err  <= bad;
                s1_data <= bad ? NOP_INST : ram[idx];
            end
        end
    end

    imem_resp_pipe #(
        .STAGES (LATENCY - 1)
    ) u_pipe (
        .clk       (clk),
        .resetb    (resetb),
        .in_valid  (s1_valid),
        .in_err    (s1_err),
        .in_data   (s1_data),
        .out_valid (imem_valid),
        .out_err   (imem_err),
        .out_data  (imem_rdata)
    );

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: drives four imem_responder instances (LATENCY 1/3/2 at
// base 0, and LATENCY 1 / DEPTH 64 at base 0x100) from shared stimulus and
// compares every output every cycle against a memory-level reference model.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int          N = 4;
    localparam int unsigned LAT_OF   [N] = '{1, 3, 2, 1};
    localparam int unsigned DEPTH_OF [N] = '{1024, 1024, 1024, 64};
    localparam logic [31:0] BASE_OF  [N] = '{32'h0, 32'h0, 32'h0, 32'h100};
    localparam logic [31:0] BOOT     [4] = '{32'h0000_0093, 32'h0010_8113,
                                             32'h0020_8193, 32'h0000_006F};
    localparam logic [31:0] ERR_ADDRS [6] = '{32'h0000_0006, 32'h0000_1000,
                                              32'h0000_00FC, 32'hFFFF_FFFC,
                                              32'h0000_0100, 32'h0000_0201};

    logic        clk;
    logic        resetb;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_wdata;

    logic        v [N];
    logic        e [N];
    logic [31:0] d [N];

    imem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
        .clk(clk), .resetb(resetb), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_rdata(d[0]), .imem_valid(v[0]), .imem_err(e[0]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

    imem_responder #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_l3 (
        .clk(clk), .resetb(resetb), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_rdata(d[1]), .imem_valid(v[1]), .imem_err(e[1]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

    imem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
        .clk(clk), .resetb(resetb), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_rdata(d[2]), .imem_valid(v[2]), .imem_err(e[2]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

    imem_responder #(.DEPTH(64), .LATENCY(1), .BASE_ADDR(32'h100)) u_b (
        .clk(clk), .resetb(resetb), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_rdata(d[3]), .imem_valid(v[3]), .imem_err(e[3]),
        .prog_we(prog_we), .prog_addr(prog_addr[5:0]), .prog_wdata(prog_wdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memories: m0 for the DEPTH=1024 instances, mb for DEPTH=64.
    logic [31:0] m0 [1024];
    logic [31:0] mb [64];

    // Expected responses, indexed by the cycle in which they must appear.
    bit          exp_v [N][8];
    bit          exp_e [N][8];
    logic [31:0] exp_d [N][8];
    int unsigned cyc = 0;

    logic [31:0] last_d [N];
    int          n_cmp = 0;
    int          n_mis = 0;

    function automatic bit model_err(input int i, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_OF[i];
        return (a[1:0] != 2'b00) || (a < BASE_OF[i]) || ((off >> 2) >= DEPTH_OF[i]);
    endfunction

    function automatic logic [31:0] model_data(input int i, input logic [31:0] a);
        logic [31:0] widx;
        if (model_err(i, a)) return NOP_INST;
        widx = (a - BASE_OF[i]) >> 2;
        return (i == 3) ? mb[widx[5:0]] : m0[widx[9:0]];
    endfunction

    // A request sampled at this edge is due LATENCY cycles later; the model
    // reads memory before applying the same-edge program write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetb) begin
            for (int i = 0; i < N; i++)
                for (int s = 0; s < 8; s++)
                    exp_v[i][s] <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_v[i][(cyc + LAT_OF[i]) % 8] <= imem_ready;
                exp_e[i][(cyc + LAT_OF[i]) % 8] <= model_err(i, imem_addr);
                exp_d[i][(cyc + LAT_OF[i]) % 8] <= model_data(i, imem_addr);
            end
            if (prog_we) begin
                m0[prog_addr]      <= prog_wdata;
                mb[prog_addr[5:0]] <= prog_wdata;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!resetb) last_d[i] = NOP_INST;
            if (exp_v[i][cyc % 8]) begin
                check_val($sformatf("u%0d_valid", i), 32'(v[i]), 32'd1);
                check_val($sformatf("u%0d_err", i), 32'(e[i]), 32'(exp_e[i][cyc % 8]));
                check_val($sformatf("u%0d_rdata", i), d[i], exp_d[i][cyc % 8]);
                last_d[i] = exp_d[i][cyc % 8];
            end else begin
                check_val($sformatf("u%0d_idle_valid", i), 32'(v[i]), 32'd0);
                check_val($sformatf("u%0d_idle_err", i), 32'(e[i]), 32'd0);
                check_val($sformatf("u%0d_hold_rdata", i), d[i], last_d[i]);
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return (32'($urandom_range(0, 1023)) << 2) + 32'($urandom_range(1, 3));
            2:       return 32'h0000_0FFC + (32'($urandom_range(0, 2)) << 2);
            3:       return 32'h0000_00FC + (32'($urandom_range(0, 2)) << 2);
            4:       return 32'h0000_0100 + (32'($urandom_range(0, 70)) << 2);
            default: return 32'($urandom_range(0, 1023)) << 2;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < N; i++) last_d[i] = NOP_INST;
        resetb = 1'b0; imem_ready = 1'b0; imem_addr = '0;
        prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        repeat (3) tick();
        resetb = 1'b1;

        // Preload the whole RAM; words 0..3 hold the boot program.
        for (int k = 0; k < 1024; k++) begin
            prog_we    = 1'b1;
            prog_addr  = 10'(k);
            prog_wdata = (k < 4) ? BOOT[k] : $urandom;
            tick();
        end
        prog_we = 1'b0;

        // Back-to-back fetches of the boot words.
        for (int k = 0; k < 4; k++) begin
            imem_ready = 1'b1;
            imem_addr  = 32'(k * 4);
            tick();
        end
        imem_ready = 1'b0;
        repeat (5) tick();

        // Isolated fetch.
        imem_ready = 1'b1; imem_addr = 32'h4;
        tick();
        imem_ready = 1'b0;
        repeat (5) tick();

        // Misaligned / out-of-range / base-boundary addresses.
        for (int k = 0; k < 6; k++) begin
            imem_ready = 1'b1; imem_addr = ERR_ADDRS[k];
            tick();
            imem_ready = 1'b0;
            repeat (4) tick();
        end

        // Write and fetch of the same word in one cycle, then fetch again.
        prog_we = 1'b1; prog_addr = 10'd2; prog_wdata = 32'hDEAD_BEEF;
        imem_ready = 1'b1; imem_addr = 32'h8;
        tick();
        prog_we = 1'b0;
        tick();
        imem_ready = 1'b0;
        repeat (4) tick();

        // Reset while requests are in flight; a write during reset is ignored.
        imem_ready = 1'b1; imem_addr = 32'h0;
        tick();
        imem_addr = 32'h4; resetb = 1'b0;
        prog_we = 1'b1; prog_addr = 10'd0; prog_wdata = 32'hBAD0_BAD0;
        tick();
        imem_ready = 1'b0;
        repeat (3) tick();
        resetb = 1'b1; prog_we = 1'b0;
        imem_ready = 1'b1; imem_addr = 32'h0;
        tick();
        imem_ready = 1'b0;
        repeat (4) tick();

        // Long idle.
        repeat (20) tick();

        // Randomised traffic with program writes and occasional reset pulses.
        for (int k = 0; k < 3000; k++) begin
            resetb     = ($urandom_range(0, 199) != 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            imem_addr  = rand_addr();
            prog_we    = ($urandom_range(0, 7) == 0);
            prog_addr  = 10'($urandom_range(0, 1023));
            prog_wdata = $urandom;
            tick();
        end
        resetb = 1'b1; imem_ready = 1'b0; prog_we = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
